// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths and write-back source encodings.
package pipe_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREG  = 32;
    localparam int unsigned AW    = $clog2(NREG);
    localparam int unsigned CNT_W = 64;

    typedef enum logic [1:0] {
        WD_SEL_ALU  = 2'b00,
        WD_SEL_DRAM = 2'b01,
        WD_SEL_PC4  = 2'b10,
        WD_SEL_EXT  = 2'b11
    } wd_sel_e;

endpackage

// File: rtl/wb_mux.sv
// Combinational 4:1 write-back value select; shared with the EX/MEM forwarding path.
module wb_mux
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN = pipe_pkg::XLEN
) (
    input  logic [1:0]      wd_sel,
    input  logic [XLEN-1:0] alu_c,
    input  logic [XLEN-1:0] dram_rd,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] sext,
    output logic [XLEN-1:0] wd
);

    always_comb begin
        wd = '0;
        unique case (wd_sel_e'(wd_sel))
            WD_SEL_ALU:  wd = alu_c;
            WD_SEL_DRAM: wd = dram_rd;
            WD_SEL_PC4:  wd = pc + XLEN'(4);
            WD_SEL_EXT:  wd = sext;
            default:     wd = '0;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// MEM/WB consumer: write-back select, register file with same-cycle bypass,
// registered retire trace and retired-instruction counter.
module wb_regfile
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN  = pipe_pkg::XLEN,
    parameter int unsigned NREG  = pipe_pkg::NREG,
    parameter int unsigned AW    = pipe_pkg::AW,
    parameter int unsigned CNT_W = pipe_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_rf_we,
    input  logic [1:0]       wb_wd_sel,
    input  logic [AW-1:0]    wb_wR,
    input  logic [XLEN-1:0]  wb_sext,
    input  logic [XLEN-1:0]  wb_rD2,
    input  logic [XLEN-1:0]  wb_alu_c,
    input  logic [XLEN-1:0]  wb_dram_rd,
    input  logic [XLEN-1:0]  wb_pc,
    input  logic             wb_whi,
    input  logic [AW-1:0]    rR1,
    input  logic [AW-1:0]    rR2,
    output logic [XLEN-1:0]  rD1,
    output logic [XLEN-1:0]  rD2,
    output logic             dbg_have_inst,
    output logic [XLEN-1:0]  dbg_pc,
    output logic             dbg_ena,
    output logic [AW-1:0]    dbg_reg,
    output logic [XLEN-1:0]  dbg_wdata,
    output logic [CNT_W-1:0] retire_cnt
);

    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] wd;
    logic            wr_nz;
    logic            byp_en;
    logic            rd2_unused;

    // rs2 travels with the instruction but plays no part in write-back.
    assign rd2_unused = ^wb_rD2;

    wb_mux #(.XLEN(XLEN)) u_wb_mux (
        .wd_sel  (wb_wd_sel),
        .alu_c   (wb_alu_c),
        .dram_rd (wb_dram_rd),
        .pc      (wb_pc),
        .sext    (wb_sext),
        .wd      (wd)
    );

    assign wr_nz  = wb_rf_we && (wb_wR != '0);
    assign byp_en = rst_n && wb_rf_we;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_nz) begin
            regs[wb_wR] <= wd;
        end
    end

    // Bypass keyed on rst_n so a write presented during reset never leaks to ID.
    always_comb begin
        rD1 = '0;
        if (rR1 != '0) begin
            if (byp_en && (wb_wR == rR1)) rD1 = wd;
            else                          rD1 = regs[rR1];
        end
    end

    always_comb begin
        rD2 = '0;
        if (rR2 != '0) begin
            if (byp_en && (wb_wR == rR2)) rD2 = wd;
            else                          rD2 = regs[rR2];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dbg_have_inst <= 1'b0;
            dbg_pc        <= '0;
            dbg_ena       <= 1'b0;
            dbg_reg       <= '0;
            dbg_wdata     <= '0;
            retire_cnt    <= '0;
        end else begin
            dbg_have_inst <= wb_whi;
            dbg_pc        <= wb_pc;
            dbg_ena       <= wb_whi && wr_nz;
            dbg_reg       <= wb_wR;
            dbg_wdata     <= wd;
            if (wb_whi) retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_rf_we;
    logic [1:0]  wb_wd_sel;
    logic [4:0]  wb_wR;
    logic [31:0] wb_sext, wb_rD2, wb_alu_c, wb_dram_rd, wb_pc;
    logic        wb_whi;
    logic [4:0]  rR1, rR2;
    logic [31:0] rD1, rD2;
    logic        dbg_have_inst;
    logic [31:0] dbg_pc;
    logic        dbg_ena;
    logic [4:0]  dbg_reg;
    logic [31:0] dbg_wdata;
    logic [63:0] retire_cnt;

    int checks = 0;
    int errors = 0;

    wb_regfile dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_rf_we      (wb_rf_we),
        .wb_wd_sel     (wb_wd_sel),
        .wb_wR         (wb_wR),
        .wb_sext       (wb_sext),
        .wb_rD2        (wb_rD2),
        .wb_alu_c      (wb_alu_c),
        .wb_dram_rd    (wb_dram_rd),
        .wb_pc         (wb_pc),
        .wb_whi        (wb_whi),
        .rR1           (rR1),
        .rR2           (rR2),
        .rD1           (rD1),
        .rD2           (rD2),
        .dbg_have_inst (dbg_have_inst),
        .dbg_pc        (dbg_pc),
        .dbg_ena       (dbg_ena),
        .dbg_reg       (dbg_reg),
        .dbg_wdata     (dbg_wdata),
        .retire_cnt    (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    logic [1:0]  sel_v [4];
    logic [31:0] exp_v [4];
    logic [9:0]  pat;

    initial begin
        rst_n = 1'b0; wb_rf_we = 1'b0; wb_wd_sel = 2'b00; wb_wR = '0;
        wb_sext = '0; wb_rD2 = 32'h1234_5678; wb_alu_c = '0; wb_dram_rd = '0;
        wb_pc = '0; wb_whi = 1'b0; rR1 = '0; rR2 = '0;

        // 1. reset with a write presented
        wb_rf_we = 1'b1; wb_wR = 5'd5; wb_alu_c = 32'hDEAD; rR1 = 5'd5;
        #1;
        tick();
        tick();
        check("rst_rd1", 64'(rD1), 64'h0);
        check("rst_cnt", retire_cnt, 64'h0);
        check("rst_have", 64'(dbg_have_inst), 64'h0);
        check("rst_ena", 64'(dbg_ena), 64'h0);
        rst_n = 1'b1; wb_rf_we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rR1 = 5'(i);
            rR2 = 5'(31 - i);
            #1;
            check("rst_regs1", 64'(rD1), 64'h0);
            check("rst_regs2", 64'(rD2), 64'h0);
        end

        // 2. each write-back source into x3
        sel_v[0] = 2'b00; exp_v[0] = 32'h0000_0011;
        sel_v[1] = 2'b01; exp_v[1] = 32'h0000_0022;
        sel_v[2] = 2'b10; exp_v[2] = 32'h0000_0000;
        sel_v[3] = 2'b11; exp_v[3] = 32'hFFFF_F800;
        wb_alu_c = 32'h11; wb_dram_rd = 32'h22; wb_pc = 32'hFFFF_FFFC; wb_sext = 32'hFFFF_F800;
        for (int i = 0; i < 4; i++) begin
            wb_rf_we = 1'b1; wb_wR = 5'd3; wb_wd_sel = sel_v[i]; rR1 = 5'd1;
            tick();
            wb_rf_we = 1'b0; rR1 = 5'd3;
            #1;
            check("src_rd1", 64'(rD1), 64'(exp_v[i]));
            check("src_wdata", 64'(dbg_wdata), 64'(exp_v[i]));
            check("src_reg", 64'(dbg_reg), 64'd3);
            check("src_ena_bubble", 64'(dbg_ena), 64'h0);
        end

        // 3. same-cycle bypass on both ports
        wb_wd_sel = 2'b00; wb_alu_c = 32'hA5A5_A5A5; wb_wR = 5'd7; wb_rf_we = 1'b1;
        rR1 = 5'd7; rR2 = 5'd7;
        #1;
        check("byp_rd1", 64'(rD1), 64'hA5A5_A5A5);
        check("byp_rd2", 64'(rD2), 64'hA5A5_A5A5);
        tick();
        wb_rf_we = 1'b0; wb_alu_c = 32'h0;
        #1;
        check("byp_stored", 64'(rD1), 64'hA5A5_A5A5);
        rR2 = 5'd3;
        #1;
        check("byp_other", 64'(rD2), 64'hFFFF_F800);

        // 4. writes to x0 are dropped
        wb_rf_we = 1'b1; wb_wR = 5'd0; wb_alu_c = 32'hFFFF_FFFF; wb_whi = 1'b1; rR1 = 5'd0;
        #1;
        check("x0_same", 64'(rD1), 64'h0);
        tick();
        wb_rf_we = 1'b0; wb_whi = 1'b0;
        #1;
        check("x0_after", 64'(rD1), 64'h0);
        check("x0_have", 64'(dbg_have_inst), 64'h1);
        check("x0_ena", 64'(dbg_ena), 64'h0);
        check("x0_wdata", 64'(dbg_wdata), 64'hFFFF_FFFF);
        check("x0_cnt", retire_cnt, 64'd1);

        // 5. trace and counter
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("tr_cnt0", retire_cnt, 64'h0);
        pat = 10'b1101101101;
        for (int i = 0; i < 10; i++) begin
            wb_whi = pat[9 - i];
            wb_pc  = 32'h100 + 32'(4 * i);
            tick();
            check("tr_have", 64'(dbg_have_inst), 64'(pat[9 - i]));
            check("tr_pc", 64'(dbg_pc), 64'h100 + 64'(4 * i));
        end
        wb_whi = 1'b0;
        check("tr_cnt7", retire_cnt, 64'd7);
        force dut.retire_cnt = '1;
        #1;
        release dut.retire_cnt;
        #1;
        check("tr_preload", retire_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
        wb_whi = 1'b1;
        tick();
        wb_whi = 1'b0;
        check("tr_wrap", retire_cnt, 64'h0);

        // 6. reset mid-stream drops the write, first post-reset write commits
        rst_n = 1'b0; wb_rf_we = 1'b1; wb_wR = 5'd9; wb_wd_sel = 2'b00; wb_alu_c = 32'h9;
        rR1 = 5'd9;
        #1;
        check("mrst_nobyp", 64'(rD1), 64'h0);
        tick();
        rst_n = 1'b1; wb_rf_we = 1'b0;
        #1;
        check("mrst_x9", 64'(rD1), 64'h0);
        wb_rf_we = 1'b1; wb_alu_c = 32'h99;
        tick();
        wb_rf_we = 1'b0;
        #1;
        check("mrst_commit", 64'(rD1), 64'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
